// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational imem,
// and buffers {pc, instr} pairs in a small FIFO handed to decode via valid/ready.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          IMEM_WORDS = 7,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        busy,
    output logic        done
);
    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam int          CW       = PW + 1;
    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_END} state_t;

    state_t          state, state_n;
    logic [31:0]     pc;
    entry_t          fifo_q [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            pop, push, push_ok, in_range, redirect;

    assign imem_addr = pc;
    assign in_range  = (pc < PC_LIMIT);
    assign redirect  = redirect_valid && (state != ST_IDLE);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push_ok   = (count < DEPTH_C) || pop;
    // A redirect wins over fetching: nothing is pushed in the flush cycle.
    assign push      = (state == ST_RUN) && !redirect && in_range && push_ok;

    assign out_instr = out_valid ? fifo_q[rd_ptr].instr : 32'h0;
    assign out_pc    = out_valid ? fifo_q[rd_ptr].pc    : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (start) state_n = ST_RUN;
            ST_RUN: begin
                if (redirect)       state_n = ST_RUN;
                else if (!in_range) state_n = ST_END;
            end
            ST_END:  if (redirect) state_n = ST_RUN;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_END) && (count == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            // Any same-cycle pop still completes; everything else is dropped.
            pc     <= redirect_pc & ~32'h3;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= '{pc: pc, instr: imem_instr};
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected {pc, instr}
// handshakes, a negedge monitor pops and compares each delivered entry.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, redirect_valid, out_ready;
    logic [31:0] redirect_pc, imem_addr, imem_instr, out_instr, out_pc;
    logic        out_valid, busy, done;

    int checks = 0;
    int fails  = 0;
    logic [63:0] exp_q [$];
    logic [31:0] rom [8];

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < 32'd28) ? rom[imem_addr[4:2]] : 32'h0;

    fetch_sequencer #(.RESET_PC(32'h0), .IMEM_WORDS(7), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_handshake", {out_pc, out_instr}, 64'hx);
            end else begin
                check("handshake", {out_pc, out_instr}, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic expect_prog(input int first);
        for (int i = first; i < 7; i++) exp_q.push_back({32'(i * 4), rom[i]});
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        while (!(exp_q.size() == 0 && done) && n < 40) begin
            step(); n++;
        end
        check({name, "_drained"}, {31'h0, exp_q.size() == 0 && done}, 64'h1);
    endtask

    initial begin
        rom[0] = 32'hF8400281; rom[1] = 32'h8B010022; rom[2] = 32'hD1000333;
        rom[3] = 32'hB40000E3; rom[4] = 32'h91002294; rom[5] = 32'hF81F4281;
        rom[6] = 32'h17FFFFFA; rom[7] = 32'h0;
        out_ready = 1'b0;
        do_reset();

        // Reset state
        check("rst_valid", {63'h0, out_valid}, 64'h0);
        check("rst_busy",  {63'h0, busy}, 64'h0);
        check("rst_done",  {63'h0, done}, 64'h0);
        check("rst_addr",  {32'h0, imem_addr}, 64'h0);
        check("rst_head",  {out_pc, out_instr}, 64'h0);

        // 1: full program at one instruction per cycle
        expect_prog(0);
        out_ready = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        check("t1_busy", {63'h0, busy}, 64'h1);
        for (int i = 0; i < 7; i++) begin
            step();
            check("t1_stream", {31'h0, out_valid, out_pc}, {31'h0, 1'b1, 32'(i * 4)});
        end
        step();
        check("t1_end", {62'h0, busy, done}, 64'h1);
        check("t1_q", 64'(exp_q.size()), 64'h0);

        // 2: backpressure holds pc at 8 with two entries buffered
        do_reset();
        expect_prog(0);
        out_ready = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("t2_hold", {imem_addr, out_pc}, {32'h8, 32'h0});
        check("t2_valid", {63'h0, out_valid}, 64'h1);
        drain("t2");

        // 3: redirect to 0x10 with pcs 4 and 8 buffered, no pop
        do_reset();
        exp_q.push_back({32'h0, rom[0]});
        out_ready = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        step(); step(); step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t3_pre", {out_pc, imem_addr}, {32'h4, 32'hC});
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        step();
        redirect_valid = 1'b0;
        check("t3_flush", {63'h0, out_valid}, 64'h0);
        step();
        check("t3_first", {out_pc, out_instr}, {32'h10, 32'h91002294});
        expect_prog(4);
        drain("t3");

        // 4: redirect to 0x6 while popping pc 0
        do_reset();
        exp_q.push_back({32'h0, rom[0]});
        out_ready = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        step();
        redirect_valid = 1'b0;
        check("t4_flush", {63'h0, out_valid}, 64'h0);
        check("t4_popped", 64'(exp_q.size()), 64'h0);
        step();
        check("t4_first", {out_pc, out_instr}, {32'h4, 32'h8B010022});
        expect_prog(1);
        drain("t4");

        // 5: redirect out of END back to 0
        check("t5_done", {63'h0, done}, 64'h1);
        expect_prog(0);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        check("t5_rerun", {62'h0, busy, done}, 64'h2);
        drain("t5");

        // 6: reset mid-run with the FIFO full
        do_reset();
        out_ready = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        step(); step(); step();
        check("t6_full", {63'h0, out_valid}, 64'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rst", {30'h0, out_valid, busy, imem_addr}, 64'h0);
        step(); step(); step();
        check("t6_idle", {30'h0, out_valid, busy, imem_addr}, 64'h0);
        check("t6_q", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
